// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter
// Round-robin arbiter that shares one 3-to-8 enable decoder among eight
// requesters. It drives the decoder index/enable (gnt_idx/gnt_valid) and the
// decoded one-hot grant. Grants are bounded by MAX_HOLD cycles. A requester
// that is revoked by the bound is locked out until it drops its request.
// Every output comes straight from a flop.
module rr_decode_arbiter #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned HCW = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [7:0]       blk_q, blk_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;

    logic [7:0]       elig_s;
    logic [3:0]       pick_s;

    // First set bit of elig scanning start, start+1, ... modulo 8.
    // Result bit 3 flags that a winner exists; bits 2:0 hold its index.
    function automatic logic [3:0] rr_pick(input logic [7:0] elig, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = start + 3'(k);
            if (elig[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Requesters that may win this cycle and the round-robin winner among them.
    always_comb begin
        elig_s = req & ~blk_q;
        pick_s = rr_pick(elig_s, ptr_q);
    end

    // Next-state logic: grant from IDLE, release or timeout from GRANT.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        // A lockout ends on any cycle where that requester is seen low.
        blk_d       = blk_q & req;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && pick_s[3]) begin
                    state_d     = ST_GRANT;
                    gnt_idx_d   = pick_s[2:0];
                    gnt_valid_d = 1'b1;
                    gnt_d       = 8'd1 << pick_s[2:0];
                    hold_cnt_d  = HCW'(1);
                end else begin
                    gnt_d       = 8'h00;
                    gnt_valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!en || !req[gnt_idx_q]) begin
                    state_d     = ST_IDLE;
                    ptr_d       = gnt_idx_q + 3'd1;
                    hold_cnt_d  = '0;
                    gnt_d       = 8'h00;
                    gnt_valid_d = 1'b0;
                end else if (hold_cnt_q == HCW'(MAX_HOLD)) begin
                    // Owner still wants the decoder: revoke and lock it out.
                    state_d          = ST_IDLE;
                    ptr_d            = gnt_idx_q + 3'd1;
                    hold_cnt_d       = '0;
                    gnt_d            = 8'h00;
                    gnt_valid_d      = 1'b0;
                    timeout_d        = 1'b1;
                    blk_d[gnt_idx_q] = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                hold_cnt_d  = '0;
                gnt_d       = 8'h00;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= '0;
            blk_q       <= 8'h00;
            gnt_q       <= 8'h00;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            blk_q       <= blk_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Testbench for rr_decode_arbiter (MAX_HOLD overridden to 4).
// Directed vector table, a hand-written asynchronous-reset sequence, and
// randomized traffic checked against a behavioural reference model.
module tb_rr_decode_arbiter;

    localparam int MAXH = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int total;
    int bad;

    rr_decode_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Hard stop if the run ever overruns.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [7:0] exp_gnt;
        logic [2:0] exp_idx;
        logic       exp_valid;
        logic       exp_to;
    } vec_t;

    vec_t tbl[$];

    // Reference model: who owns the decoder, for how long, rotation start,
    // and which requesters are locked out after a timeout.
    bit m_busy;
    int m_owner;
    int m_cnt;
    int m_ptr;
    int m_idx;
    bit m_to;
    bit m_blk[8];

    task automatic m_reset();
        m_busy = 1'b0;
        m_owner = 0;
        m_cnt = 0;
        m_ptr = 0;
        m_idx = 0;
        m_to = 1'b0;
        for (int i = 0; i < 8; i++) m_blk[i] = 1'b0;
    endtask

    task automatic m_step(input logic e, input logic [7:0] r);
        int win;
        win = -1;
        m_to = 1'b0;
        if (!m_busy && e) begin
            for (int k = 0; k < 8; k++) begin
                int i;
                i = (m_ptr + k) % 8;
                if (win < 0 && r[i] && !m_blk[i]) win = i;
            end
        end
        for (int i = 0; i < 8; i++) if (!r[i]) m_blk[i] = 1'b0;
        if (!m_busy) begin
            if (win >= 0) begin
                m_busy = 1'b1;
                m_owner = win;
                m_idx = win;
                m_cnt = 1;
            end
        end else if (!e || !r[m_owner]) begin
            m_busy = 1'b0;
            m_ptr = (m_owner + 1) % 8;
        end else if (m_cnt == MAXH) begin
            m_busy = 1'b0;
            m_ptr = (m_owner + 1) % 8;
            m_to = 1'b1;
            m_blk[m_owner] = 1'b1;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs, take one rising edge, advance the model, settle.
    task automatic step(input logic e, input logic [7:0] r);
        en = e;
        req = r;
        @(posedge clk);
        m_step(e, r);
        #1;
    endtask

    task automatic chk_model(input string tag);
        logic [7:0] eg;
        eg = m_busy ? (8'h01 << m_owner) : 8'h00;
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_busy));
        chk({tag, ".gnt_idx"}, 32'(gnt_idx), 32'(m_idx));
        chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    endtask

    task automatic add(input logic e, input logic [7:0] r, input logic [7:0] g,
                       input logic [2:0] ix, input logic v, input logic t);
        vec_t x;
        x.en = e; x.req = r; x.exp_gnt = g; x.exp_idx = ix; x.exp_valid = v; x.exp_to = t;
        tbl.push_back(x);
    endtask

    initial begin
        logic [7:0] rq;
        logic       re;
        total = 0;
        bad = 0;
        clk = 1'b0;
        rst_n = 1'b0;
        en = 1'b1;
        req = 8'hFF;
        m_reset();

        // Directed vectors: {en, req} -> {gnt, gnt_idx, gnt_valid, timeout}
        add(1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0); // first edge after reset
        add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0); // single requester 3
        add(1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
        add(1'b1, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0); // release, ptr -> 4
        add(1'b1, 8'h18, 8'h10, 3'd4, 1'b1, 1'b0); // 4 beats 3
        add(1'b1, 8'h00, 8'h00, 3'd4, 1'b0, 1'b0); // ptr -> 5
        add(1'b1, 8'h81, 8'h80, 3'd7, 1'b1, 1'b0); // wrap: 7
        add(1'b1, 8'h81, 8'h80, 3'd7, 1'b1, 1'b0);
        add(1'b1, 8'h01, 8'h00, 3'd7, 1'b0, 1'b0); // idle gap, ptr -> 0
        add(1'b1, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0); // 0
        add(1'b1, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0);
        add(1'b1, 8'h80, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b1, 8'h81, 8'h80, 3'd7, 1'b1, 1'b0); // 7
        add(1'b1, 8'h81, 8'h80, 3'd7, 1'b1, 1'b0);
        add(1'b1, 8'h01, 8'h00, 3'd7, 1'b0, 1'b0);
        add(1'b1, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0); // 0
        add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0); // ptr -> 1
        add(1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0); // timeout run, cycle 1
        add(1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0); // 2
        add(1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0); // 3
        add(1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0); // 4
        add(1'b1, 8'h04, 8'h00, 3'd2, 1'b0, 1'b1); // revoked, pulse
        add(1'b1, 8'h04, 8'h00, 3'd2, 1'b0, 1'b0); // locked out
        add(1'b1, 8'h04, 8'h00, 3'd2, 1'b0, 1'b0);
        add(1'b1, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0); // drop clears lockout
        add(1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0); // granted again
        add(1'b1, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0);
        add(1'b0, 8'h10, 8'h00, 3'd2, 1'b0, 1'b0); // en low: no grant
        add(1'b0, 8'h10, 8'h00, 3'd2, 1'b0, 1'b0);
        add(1'b1, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0); // en high: grant 4
        add(1'b0, 8'h10, 8'h00, 3'd4, 1'b0, 1'b0); // en low mid-grant
        add(1'b1, 8'h30, 8'h20, 3'd5, 1'b1, 1'b0); // ptr was 5: 5 beats 4

        // Reset state with requests and enable active.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.gnt", 32'(gnt), 32'h00);
        chk("rst.gnt_valid", 32'(gnt_valid), 32'h0);
        chk("rst.gnt_idx", 32'(gnt_idx), 32'h0);
        chk("rst.timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;
        m_reset();

        for (int n = 0; n < tbl.size(); n++) begin
            string tg;
            step(tbl[n].en, tbl[n].req);
            tg = $sformatf("vec%0d", n);
            chk({tg, ".gnt"}, 32'(gnt), 32'(tbl[n].exp_gnt));
            chk({tg, ".gnt_idx"}, 32'(gnt_idx), 32'(tbl[n].exp_idx));
            chk({tg, ".gnt_valid"}, 32'(gnt_valid), 32'(tbl[n].exp_valid));
            chk({tg, ".timeout"}, 32'(timeout), 32'(tbl[n].exp_to));
        end

        // Asynchronous reset mid-grant (gnt=8'h20), between clock edges.
        #3;
        chk("pre_arst.gnt", 32'(gnt), 32'h20);
        rst_n = 1'b0;
        #1;
        chk("arst.gnt", 32'(gnt), 32'h00);
        chk("arst.gnt_valid", 32'(gnt_valid), 32'h0);
        chk("arst.gnt_idx", 32'(gnt_idx), 32'h0);
        @(posedge clk);
        #1;
        chk("arst_hold.gnt", 32'(gnt), 32'h00);
        rst_n = 1'b1;
        m_reset();
        step(1'b1, 8'h30);
        chk("post_arst.gnt", 32'(gnt), 32'h10);
        step(1'b1, 8'h00);

        // Randomized traffic: requests mostly persist, bits toggle occasionally.
        rq = 8'h00;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
            end
            re = ($urandom_range(0, 11) != 0);
            step(re, rq);
            chk_model($sformatf("rnd%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
